ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arb_pkg.sv | 25 ++
 rtl/ram_arbiter_arb2.sv | 43 ++++
 rtl/ram_arbiter.sv | 111 +++++++++++
 tb/tb_ram_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package ram_arb_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RDATA = 2'd2
    } arb_state_t;

    // One requester's access as presented on its port
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } ram_req_t;

    // Select the winning requester's access fields
    function automatic ram_req_t pick_req(input logic sel, input ram_req_t r0, input ram_req_t r1);
        return sel ? r1 : r0;
    endfunction

endpackage

// File: rtl/ram_arbiter_arb2.sv
// 2-way grant selection for the RAM arbiter.
// RAM_ARB_ROUND_ROBIN_EN: ties alternate using a last_grant register;
// otherwise requester 0 always wins a tie.
module arb2 (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic take,      // the current winner is being accepted this edge
    output logic win_id,    // 0 = requester 0, 1 = requester 1
    output logic win_any
);

    assign win_any = req0 | req1;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic last_grant;

    // Tie goes to the requester not granted last; a lone request always wins
    always_comb begin
        win_id = 1'b0;
        if (req0 && req1)
            win_id = ~last_grant;
        else
            win_id = req1;
    end

    // Remember who was granted; reset value 1 makes requester 0 win the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_grant <= 1'b1;
        else if (take)
            last_grant <= win_id;
    end
`else
    // Fixed priority: requester 0 wins whenever it asks
    assign win_id = req1 & ~req0;

    logic unused_arb;
    assign unused_arb = &{1'b0, clk, rst, take};
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single-port 16x8 synchronous RAM.
// Each access: IDLE (sample) -> ISSUE (drive RAM, pulse gnt) -> [RDATA] -> IDLE.
// RAM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking in arb2.
module ram_arbiter
    import ram_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] ram_din,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr_en,
    input  logic [DATA_W-1:0] ram_out
);

    arb_state_t state, state_nxt;
    logic       win_id, win_any, accept;
    logic       lat_we, lat_id;
    ram_req_t   win_req;

    assign accept  = (state == IDLE) && win_any;
    assign win_req = pick_req(win_id,
                              ram_req_t'{we0, addr0, wdata0},
                              ram_req_t'{we1, addr1, wdata1});

    arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .req1    (req1),
        .take    (accept),
        .win_id  (win_id),
        .win_any (win_any)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state and ISSUE-cycle strobes; strobes decode from state so reset kills them at once
    always_comb begin
        state_nxt = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        ram_wr_en = 1'b0;
        case (state)
            IDLE: begin
                if (win_any)
                    state_nxt = ISSUE;
            end
            ISSUE: begin
                gnt0      = ~lat_id;
                gnt1      = lat_id;
                ram_wr_en = lat_we;
                state_nxt = lat_we ? IDLE : RDATA;
            end
            RDATA: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Latch the winner; ram_addr/ram_din double as the address/data latch and hold between accesses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_addr <= '0;
            ram_din  <= '0;
            lat_we   <= 1'b0;
            lat_id   <= 1'b0;
        end else if (accept) begin
            ram_addr <= win_req.addr;
            ram_din  <= win_req.wdata;
            lat_we   <= win_req.we;
            lat_id   <= win_id;
        end
    end

    // Capture RAM output at the end of RDATA; rvalid pulses the cycle after
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata   <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            rvalid0 <= (state == RDATA) && !lat_id;
            rvalid1 <= (state == RDATA) &&  lat_id;
            if (state == RDATA)
                rdata <= ram_out;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: transaction-level model plus directed vectors.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [3:0] addr0 = 0, addr1 = 0;
    logic [7:0] wdata0 = 0, wdata1 = 0;
    logic       gnt0, gnt1, rvalid0, rvalid1, ram_wr_en;
    logic [7:0] rdata, ram_din, ram_out;
    logic [3:0] ram_addr;

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .ram_din(ram_din), .ram_addr(ram_addr),
        .ram_wr_en(ram_wr_en), .ram_out(ram_out)
    );

    // 16x8 synchronous RAM seen by the arbiter
    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_addr] <= ram_din;
        ram_out <= mem[ram_addr];
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: accept when free, schedule gnt at +0 and rvalid at +2 edges
    int         cyc = 0, free_at = 0;
    int         g_id [int];
    bit         g_we [int];
    int         rv_id [int];
    logic [7:0] rv_dat [int];
    logic [7:0] ref_mem [16];
    logic [3:0] e_addr = 0;
    logic [7:0] e_din = 0, e_rdata = 0;
    bit         last_grant = 1'b1;
    bit         mw, mwe;
    logic [3:0] ma;
    logic [7:0] md;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc = 0; free_at = 0;
            g_id.delete(); g_we.delete(); rv_id.delete(); rv_dat.delete();
            e_addr = 0; e_din = 0; e_rdata = 0; last_grant = 1'b1;
        end else begin
            cyc++;
            if (rv_id.exists(cyc)) e_rdata = rv_dat[cyc];
            if (cyc >= free_at && (req0 || req1)) begin
                if (req0 && req1) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
                    mw = !last_grant;
`else
                    mw = 1'b0;
`endif
                end else begin
                    mw = req1;
                end
                last_grant = mw;
                mwe = mw ? we1 : we0;
                ma  = mw ? addr1 : addr0;
                md  = mw ? wdata1 : wdata0;
                g_id[cyc] = mw ? 2 : 1;
                g_we[cyc] = mwe;
                e_addr = ma;
                e_din  = md;
                if (mwe) begin
                    ref_mem[ma] = md;
                    free_at = cyc + 2;
                end else begin
                    rv_id[cyc+2]  = mw ? 2 : 1;
                    rv_dat[cyc+2] = ref_mem[ma];
                    free_at = cyc + 3;
                end
            end
        end
    end

    // Compare every cycle, away from the active edge
    int eg, er;
    bit ew;
    always @(negedge clk) begin
        eg = g_id.exists(cyc) ? g_id[cyc] : 0;
        ew = (eg != 0) && g_we[cyc];
        er = rv_id.exists(cyc) ? rv_id[cyc] : 0;
        chk("gnt0",      gnt0,      eg == 1);
        chk("gnt1",      gnt1,      eg == 2);
        chk("ram_wr_en", ram_wr_en, ew);
        chk("rvalid0",   rvalid0,   er == 1);
        chk("rvalid1",   rvalid1,   er == 2);
        chk("ram_addr",  ram_addr,  e_addr);
        chk("ram_din",   ram_din,   e_din);
        chk("rdata",     rdata,     e_rdata);
    end

    // One complete access from requester id; returns ISSUE-cycle RAM strobes and read data
    task automatic access(input bit id, input bit we, input logic [3:0] a, input logic [7:0] d,
                          output logic s_wr, output logic [3:0] s_a, output logic [7:0] s_d,
                          output logic [7:0] rd);
        int n;
        @(negedge clk);
        if (id) begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
        else    begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
        n = 0;
        do begin @(negedge clk); n++; end while (!(id ? gnt1 : gnt0) && n < 10);
        chk("gnt_latency", n, 1);
        s_wr = ram_wr_en; s_a = ram_addr; s_d = ram_din;
        if (id) req1 = 0; else req0 = 0;
        rd = 8'hxx;
        if (!we) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!(id ? rvalid1 : rvalid0) && n < 10);
            chk("rvalid_latency", n, 2);
            rd = rdata;
        end
    endtask

    initial begin
        logic       s_wr;
        logic [3:0] s_a;
        logic [7:0] s_d, rd;
        int         gq[$], gt[$];
        int         ex;
        for (int i = 0; i < 16; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end

        repeat (2) @(negedge clk);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_addr",  ram_addr, 4'h0);
        chk("rst_gnt",   {gnt0, gnt1, rvalid0, rvalid1, ram_wr_en}, 5'b0);
        #1 rst = 0;

        // write 93 to addr 3 from requester 0
        access(0, 1, 4'h3, 8'h93, s_wr, s_a, s_d, rd);
        chk("wr_en_issue", s_wr, 1'b1);
        chk("wr_addr",     s_a, 4'h3);
        chk("wr_din",      s_d, 8'h93);
        @(negedge clk);
        chk("wr_en_one_cycle", ram_wr_en, 1'b0);

        // read it back from requester 1
        access(1, 0, 4'h3, 8'h00, s_wr, s_a, s_d, rd);
        chk("rd_issue_wr_en", s_wr, 1'b0);
        chk("rd1_data", rd, 8'h93);
        chk("rv0_quiet", rvalid0, 1'b0);

        // address extremes, no aliasing
        access(0, 1, 4'hF, 8'hFF, s_wr, s_a, s_d, rd);
        access(1, 1, 4'h0, 8'h01, s_wr, s_a, s_d, rd);
        access(0, 0, 4'hF, 8'h00, s_wr, s_a, s_d, rd);
        chk("rd_addrF", rd, 8'hFF);
        access(1, 0, 4'h0, 8'h00, s_wr, s_a, s_d, rd);
        chk("rd_addr0", rd, 8'h01);

        // reset during RDATA of a read abandons it
        @(negedge clk); req0 = 1; we0 = 0; addr0 = 4'hF;
        @(negedge clk); chk("gnt0_before_rst", gnt0, 1'b1); req0 = 0;
        @(posedge clk); #2 rst = 1;
        #1;
        chk("rst_mid_rvalid", rvalid0, 1'b0);
        chk("rst_mid_rdata",  rdata, 8'h00);
        chk("rst_mid_addr",   ram_addr, 4'h0);
        @(negedge clk); #1 rst = 0; req0 = 1; we0 = 1; addr0 = 4'h5; wdata0 = 8'h5A;
        @(posedge clk); #1;
        chk("gnt_after_rst", gnt0, 1'b1);
        chk("wr_after_rst",  ram_wr_en, 1'b1);
        chk("addr_after_rst", ram_addr, 4'h5);
        @(negedge clk); req0 = 0;
        repeat (3) @(negedge clk);

        // fresh reset, then both requesters reading continuously
        #1 rst = 1;
        @(negedge clk); #1 rst = 0;
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 4'hF; addr1 = 4'h0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (gnt0) begin gq.push_back(0); gt.push_back(i); end
            if (gnt1) begin gq.push_back(1); gt.push_back(i); end
        end
        req0 = 0; req1 = 0;
        chk("tie_grant_count", gq.size(), 4);
        for (int k = 0; k < 4; k++) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
            ex = k % 2;
`else
            ex = 0;
`endif
            if (k < gq.size()) begin
                chk("tie_order",   gq[k], ex);
                chk("tie_spacing", gt[k], 3 * k);
            end
        end
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
